signed_mac_drain: RTL
=====================

// Module: signed_mac_drain
// PURPOSE
//  Downstream stage of the signed 8x8 multiplier. Consumes the registered
//  16-bit signed product RES, saturating-accumulates a programmed number of
//  products, then drains the sum over an 8-bit pad-limited output, MSB byte
//  first, with a valid/ack handshake. Sits between multiplier RES and pads.
// PARAMETERS
//  PW  16  product width (signed), matches multiplier RES
//  AW  24  accumulator width (signed); must be a multiple of 8 and >= PW
//  NW   8  width of product-count input len
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   1-cycle pulse: begin new accumulation (IDLE only)
//  len       in   NW  number of products to accumulate, sampled on start
//  prod      in   PW  signed product (multiplier RES)
//  prod_vld  in   1   prod is valid this cycle
//  busy      out  1   high in ACC and DRAIN
//  dout      out  8   current result byte
//  dout_vld  out  1   dout holds a valid byte
//  dout_ack  in   1   consumer took dout this cycle
//  ovf       out  1   sticky: saturation occurred in current run
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, cnt=0, busy=0, dout=8'h00, dout_vld=0, ovf=0.
//   rst mid-ACC/DRAIN aborts immediately; partial sum is discarded.
//  FSM states IDLE, ACC, DRAIN; all outputs registered.
//  IDLE: start=1 -> acc<=0, ovf<=0, cnt<=len; len!=0 -> ACC;
//   len==0 -> DRAIN with sum 0.
//  ACC: on prod_vld: acc<=sat(acc+sext(prod)), cnt<=cnt-1; the product
//   accepted when cnt==1 is the last one -> DRAIN next cycle, shift register
//   loaded with the final (post-add) acc. No prod_vld -> hold.
//  DRAIN: NB=AW/8 bytes, MSB first. Entry cycle: dout=byte NB-1, dout_vld=1.
//   dout_ack while dout_vld -> next byte on next edge; ack on last byte ->
//   dout_vld<=0, dout<=0, IDLE. dout/dout_vld stable while un-acked.
//   dout_ack while dout_vld=0 is ignored.
//  Saturation: true sum wider than AW clamps to +2^(AW-1)-1 or -2^(AW-1);
//   ovf<=1 and stays set until next accepted start. Accumulation continues
//   from the clamped value.
//  start outside IDLE is ignored (no restart). prod_vld outside ACC ignored.
//  start and prod_vld in same IDLE cycle: prod not accumulated.
//  Multiplier output latency is the producer's concern: prod_vld must align
//   with the cycle prod (RES) carries the intended product.
//  busy = (state != IDLE); min run: start -> first dout_vld in len+1 cycles
//   with prod_vld held high.
// STRUCTURE
//  Shared package: state encodings (ST_IDLE/ST_ACC/ST_DRAIN), NB=AW/8,
//   SAT_MAX/SAT_MIN constants derived from AW.
//  One sub-module: sat_add (AW-bit signed + sign-extended PW-bit,
//   outputs clamped sum and overflow flag), purely combinational.
//  Top holds FSM, cnt, acc register, byte shift register, handshake.
// TESTING
//  1. len=3, prods 100,-50,25, ack every cycle -> bytes 00,00,4B; ovf=0.
//  2. len=2, prods -1,-1 -> bytes FF,FF,FE; busy drops after 3rd ack.
//  3. AW=16, len=3, prod 16384 x3 -> bytes 7F,FF, ovf=1; prod -16256 x3
//     -> 80,00, ovf=1; next start clears ovf.
//  4. len=0 start -> DRAIN next cycle, bytes 00,00,00, no prods consumed.
//  5. Gaps: prod_vld toggling, ack held low 5 cycles per byte -> dout stable,
//     result identical to test 1; start pulses while busy ignored.
//  6. rst asserted mid-ACC and mid-DRAIN -> all outputs to reset values
//     asynchronously; fresh run afterwards gives correct sum.

Source files
------------

// File: rtl/signed_mac_drain_pkg.sv
// Shared definitions for the signed MAC drain stage: FSM state encoding,
// byte-count helper and saturation limits derived from the accumulator width.
package signed_mac_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Number of output bytes needed to drain an accumulator of width aw
  function automatic int nbOf(input int aw);
    return aw / 8;
  endfunction

  // Largest positive value representable in aw-bit two's complement
  function automatic longint satMaxOf(input int aw);
    return (longint'(1) <<< (aw - 1)) - longint'(1);
  endfunction

  // Most negative value representable in aw-bit two's complement
  function automatic longint satMinOf(input int aw);
    return -(longint'(1) <<< (aw - 1));
  endfunction

endpackage

// File: rtl/signed_mac_drain_sat_add.sv
// Combinational saturating adder: AW-bit signed accumulator plus a
// sign-extended PW-bit product, clamped to the AW-bit signed range.
module signed_mac_drain_sat_add
  import signed_mac_drain_pkg::*;
#(
  parameter int PW = 16,
  parameter int AW = 24
) (
  input  logic signed [AW-1:0] acc_i,
  input  logic signed [PW-1:0] prod_i,
  output logic signed [AW-1:0] sum_o,
  output logic                 ovf_o
);

  localparam logic signed [AW-1:0] SAT_MAX = AW'(satMaxOf(AW));
  localparam logic signed [AW-1:0] SAT_MIN = AW'(satMinOf(AW));

  logic signed [AW:0] wideSum;

  // One guard bit is enough since AW >= PW; a guard/sign disagreement means
  // the true sum left the AW-bit range and the guard bit gives its direction.
  always_comb begin
    wideSum = (AW+1)'(acc_i) + (AW+1)'(prod_i);
    ovf_o   = wideSum[AW] ^ wideSum[AW-1];
    if (ovf_o) begin
      sum_o = wideSum[AW] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = wideSum[AW-1:0];
    end
  end

endmodule

// File: rtl/signed_mac_drain.sv
// Signed MAC drain stage: saturating-accumulates len products from the
// multiplier, then hands the sum out over an 8-bit port, MSB byte first,
// using a valid/ack handshake. All outputs come straight from registers.
module signed_mac_drain
  import signed_mac_drain_pkg::*;
#(
  parameter int PW = 16,
  parameter int AW = 24,
  parameter int NW = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NW-1:0]        len_i,
  input  logic signed [PW-1:0] prod_i,
  input  logic                 prod_vld_i,
  output logic                 busy_o,
  output logic [7:0]           dout_o,
  output logic                 dout_vld_o,
  input  logic                 dout_ack_i,
  output logic                 ovf_o
);

  localparam int NB = nbOf(AW);
  localparam int SW = AW - 8;
  localparam int RW = (NB > 1) ? $clog2(NB) : 1;

  state_e state_q, state_d;

  logic signed [AW-1:0] acc_q, acc_d;
  logic [NW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        shift_q, shift_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic [7:0]           dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 ovf_q, ovf_d;

  logic signed [AW-1:0] addSum;
  logic                 addOvf;

  signed_mac_drain_sat_add #(
    .PW(PW),
    .AW(AW)
  ) u_sat_add (
    .acc_i (acc_q),
    .prod_i(prod_i),
    .sum_o (addSum),
    .ovf_o (addOvf)
  );

  // Next-state and next-output logic; dout holds the current byte while the
  // shift register keeps only the bytes still waiting to go out.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d  = '0;
          ovf_d  = 1'b0;
          cnt_d  = len_i;
          busy_d = 1'b1;
          if (len_i != '0) begin
            state_d = ST_ACC;
          end else begin
            state_d = ST_DRAIN;
            shift_d = '0;
            dout_d  = 8'h00;
            vld_d   = 1'b1;
            rem_d   = RW'(NB - 1);
          end
        end
      end
      ST_ACC: begin
        if (prod_vld_i) begin
          acc_d = addSum;
          ovf_d = ovf_q | addOvf;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == NW'(1)) begin
            state_d = ST_DRAIN;
            dout_d  = addSum[AW-1 -: 8];
            shift_d = addSum[SW-1:0];
            vld_d   = 1'b1;
            rem_d   = RW'(NB - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (dout_ack_i && vld_q) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            dout_d  = 8'h00;
            busy_d  = 1'b0;
          end else begin
            dout_d  = shift_q[SW-1 -: 8];
            shift_d = shift_q << 8;
            rem_d   = rem_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run in progress immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; a reset discards any partial sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o     = busy_q;
  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;
  assign ovf_o      = ovf_q;

endmodule
